pipelined_adder_tree: RTL and testbench

Parametrised, fully pipelined N-input adder tree. It sums NUM_IN operands of IN_W bits each at full precision, so no operand width is truncated. It adds a valid pipeline, a clock-enable stall, and a signed/unsigned mode. It is the generalised successor to the fixed 5-input 16-bit tree, used in the datapath wherever wide multi-operand reductions feed downstream accumulators and filters.

---
 rtl/pipelined_adder_tree_pkg.sv | 62 ++++++
 rtl/pipelined_adder_tree_level.sv | 61 ++++++
 rtl/pipelined_adder_tree.sv | 134 +++++++++++++
 tb/tb_pipelined_adder_tree.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_pkg
//  Description : Elaboration-time helpers for the pipelined adder tree:
//                ceil-log2, level count, output width, per-level element
//                counts and offsets into the flattened inter-level bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

   localparam int MAX_NUM_IN = 64;
   localparam int MAX_IN_W   = 32;

   // Integer ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Number of pairwise-reduction levels needed to reach one element.
   function automatic int tree_levels(input int num_in);
      return clog2(num_in);
   endfunction

   // Full-precision result width: each level can add at most one carry bit.
   function automatic int tree_out_w(input int in_w, input int num_in);
      return in_w + tree_levels(num_in);
   endfunction

   // Element count produced by level lvl. A negative lvl yields the operand
   // count itself, so level_count(n, l-1) is the input count of level l.
   function automatic int level_count(input int num_in, input int lvl);
      int n;
      n = num_in;
      for (int i = 0; i < 32; i++) begin
         if (i <= lvl) n = (n + 1) / 2;
      end
      return n;
   endfunction

   // Element offset of the input vector of level lvl inside the flattened
   // bus that chains the extended operands and every level output.
   function automatic int level_offset(input int num_in, input int lvl);
      int off;
      int n;
      off = 0;
      n   = num_in;
      for (int i = 0; i < 32; i++) begin
         if (i < lvl) begin
            off = off + n;
            n   = (n + 1) / 2;
         end
      end
      return off;
   endfunction

endpackage : adder_tree_pkg
`default_nettype wire

// File: rtl/pipelined_adder_tree_level.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_level
//  Description : One registered pairwise-reduction level. Elements 2p and
//                2p+1 are summed into output p; with an odd count the last
//                element is registered unchanged. All elements are W wide.
//  Ports       : clk      - rising-edge clock
//                rst      - asynchronous active-high reset (clears outputs)
//                ce       - clock enable; 0 holds the level register
//                in_data  - N_IN packed elements, element k at [k*W +: W]
//                out_data - ceil(N_IN/2) packed registered elements
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_level #(
   parameter int N_IN   = 2,
   parameter int W      = 8,
   parameter int SIGNED = 0,
   localparam int N_OUT = (N_IN + 1) / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [N_IN*W-1:0]    in_data,
   output logic [N_OUT*W-1:0]   out_data
);

   logic [N_OUT*W-1:0] w_next;
   logic [N_OUT*W-1:0] r_data;

   generate
      for (genvar p = 0; p < N_IN / 2; p++) begin : g_pair
         // Two's-complement and unsigned addition produce identical bits at
         // equal width; the split keeps the operand interpretation explicit.
         if (SIGNED != 0) begin : g_signed
            assign w_next[p*W +: W] = $signed(in_data[(2*p)*W +: W])
                                    + $signed(in_data[(2*p+1)*W +: W]);
         end else begin : g_unsigned
            assign w_next[p*W +: W] = in_data[(2*p)*W +: W]
                                    + in_data[(2*p+1)*W +: W];
         end
      end

      // Odd element rides through on a plain register, no adder against zero.
      if ((N_IN % 2) != 0) begin : g_odd
         assign w_next[(N_OUT-1)*W +: W] = in_data[(N_IN-1)*W +: W];
      end
   endgenerate

   // Data loads on every enabled edge regardless of valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if (ce) begin
         r_data <= w_next;
      end
   end

   assign out_data = r_data;

endmodule : adder_tree_level
`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_tree
//  Description : Fully pipelined NUM_IN-operand adder tree with full-precision
//                result, valid pipeline, clock-enable stall and signed or
//                unsigned operand mode. Latency is LEVELS + OUT_REG enabled
//                clock edges; throughput one vector per enabled cycle.
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-high reset
//                ce        - clock enable; 0 freezes all data and valid regs
//                in_valid  - operand vector valid this cycle
//                in_data   - NUM_IN packed operands, k at [k*IN_W +: IN_W]
//                out_valid - out_sum holds a valid result
//                out_sum   - full-precision sum, IN_W + LEVELS bits
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder_tree
   import adder_tree_pkg::*;
#(
   parameter int NUM_IN  = 5,
   parameter int IN_W    = 16,
   parameter int SIGNED  = 0,
   parameter int OUT_REG = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   ce,
   input  logic                                   in_valid,
   input  logic [NUM_IN*IN_W-1:0]                 in_data,
   output logic                                   out_valid,
   output logic [tree_out_w(IN_W, NUM_IN)-1:0]    out_sum
);

   localparam int c_levels    = tree_levels(NUM_IN);
   localparam int c_out_w     = tree_out_w(IN_W, NUM_IN);
   localparam int c_latency   = c_levels + ((OUT_REG != 0) ? 1 : 0);
   localparam int c_final_off = level_offset(NUM_IN, c_levels);
   localparam int c_total     = c_final_off + 1;

   // Flattened chain: extended operands, then each level's output in turn.
   logic [c_total*c_out_w-1:0] w_tree;
   logic [c_out_w-1:0]         w_final;
   logic [c_latency-1:0]       r_valid;

   // ------------------------------------------------------------------
   // Operand extension to the full result width
   // ------------------------------------------------------------------
   generate
      for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
         if (SIGNED != 0) begin : g_sext
            assign w_tree[k*c_out_w +: c_out_w] =
               {{c_levels{in_data[k*IN_W + IN_W - 1]}}, in_data[k*IN_W +: IN_W]};
         end else begin : g_zext
            assign w_tree[k*c_out_w +: c_out_w] =
               {{c_levels{1'b0}}, in_data[k*IN_W +: IN_W]};
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Reduction levels; level l reads the segment written by level l-1
   // ------------------------------------------------------------------
   generate
      for (genvar l = 0; l < c_levels; l++) begin : g_level
         localparam int c_n_in    = level_count(NUM_IN, l - 1);
         localparam int c_n_out   = level_count(NUM_IN, l);
         localparam int c_in_off  = level_offset(NUM_IN, l);
         localparam int c_out_off = level_offset(NUM_IN, l + 1);

         adder_tree_level #(
            .N_IN   (c_n_in),
            .W      (c_out_w),
            .SIGNED (SIGNED)
         ) u_level (
            .clk      (clk),
            .rst      (rst),
            .ce       (ce),
            .in_data  (w_tree[c_in_off*c_out_w +: c_n_in*c_out_w]),
            .out_data (w_tree[c_out_off*c_out_w +: c_n_out*c_out_w])
         );
      end
   endgenerate

   assign w_final = w_tree[c_final_off*c_out_w +: c_out_w];

   // ------------------------------------------------------------------
   // Valid pipeline, same depth and enable as the data path
   // ------------------------------------------------------------------
   generate
      if (c_latency == 1) begin : g_valid_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_valid <= '0;
            end else if (ce) begin
               r_valid <= in_valid;
            end
         end
      end else begin : g_valid_chain
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_valid <= '0;
            end else if (ce) begin
               r_valid <= {r_valid[c_latency-2:0], in_valid};
            end
         end
      end
   endgenerate

   assign out_valid = r_valid[c_latency-1];

   // ------------------------------------------------------------------
   // Output stage: optional extra register, never a combinational path
   // ------------------------------------------------------------------
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [c_out_w-1:0] r_sum;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sum <= '0;
            end else if (ce) begin
               r_sum <= w_final;
            end
         end

         assign out_sum = r_sum;
      end else begin : g_out_direct
         // Final level is already a register cleared by rst.
         assign out_sum = w_final;
      end
   endgenerate

endmodule : pipelined_adder_tree
`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder_tree
//  Description : Scoreboard bench for pipelined_adder_tree. Six instances
//                share clk/rst/ce/in_valid: the default unsigned tree, a
//                SIGNED=1 tree fed the same operands, and four small
//                parameter points. Stimulus pushes expected results tagged
//                with the enabled-edge count; a negedge monitor pops and
//                checks value and latency, and checks holding under ce=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder_tree;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        in_valid;
   logic [79:0] d0;
   logic [71:0] d2;
   logic [1:0]  d3;
   logic [23:0] d4;
   logic [7:0]  d5;

   logic        v0, v1, v2, v3, v4, v5;
   logic [18:0] s0, s1;
   logic [11:0] s2;
   logic [1:0]  s3;
   logic [9:0]  s4;
   logic [3:0]  s5;

   always #5 clk = ~clk;

   pipelined_adder_tree #(.NUM_IN(5), .IN_W(16), .SIGNED(0), .OUT_REG(1)) u_dut0 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d0),
      .out_valid(v0), .out_sum(s0));
   pipelined_adder_tree #(.NUM_IN(5), .IN_W(16), .SIGNED(1), .OUT_REG(1)) u_dut1 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d0),
      .out_valid(v1), .out_sum(s1));
   pipelined_adder_tree #(.NUM_IN(9), .IN_W(8), .SIGNED(0), .OUT_REG(1)) u_dut2 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d2),
      .out_valid(v2), .out_sum(s2));
   pipelined_adder_tree #(.NUM_IN(2), .IN_W(1), .SIGNED(0), .OUT_REG(0)) u_dut3 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d3),
      .out_valid(v3), .out_sum(s3));
   pipelined_adder_tree #(.NUM_IN(3), .IN_W(8), .SIGNED(0), .OUT_REG(0)) u_dut4 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d4),
      .out_valid(v4), .out_sum(s4));
   pipelined_adder_tree #(.NUM_IN(8), .IN_W(1), .SIGNED(0), .OUT_REG(1)) u_dut5 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(d5),
      .out_valid(v5), .out_sum(s5));

   typedef struct {
      logic [63:0] sum;
      int          stamp;
   } exp_t;

   exp_t        exp_q [6][$];
   // LEVELS + OUT_REG per instance: 3+1, 3+1, 4+1, 1+0, 2+0, 3+1
   int          lat [6] = '{4, 4, 5, 1, 2, 4};
   int          checks = 0;
   int          errors = 0;
   int          en_cnt = 0;
   bit          last_ce = 1'b0;
   logic        prev_v [6];
   logic [63:0] prev_s [6];

   // Enabled-edge counter; stimulus and monitor run away from this edge.
   always @(posedge clk) begin
      last_ce = ce;
      if (ce && !rst) en_cnt++;
   end

   function automatic logic [63:0] ref_sum(input logic [127:0] d, input int n,
                                           input int w, input int ow);
      longint acc;
      longint op;
      acc = 0;
      for (int k = 0; k < n; k++) begin
         op  = longint'((d >> (k * w)) & ((128'd1 << w) - 128'd1));
         acc = acc + op;
      end
      return 64'(acc) & ((64'd1 << ow) - 64'd1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input int id, input logic [63:0] sum);
      exp_t e;
      e.sum   = sum;
      e.stamp = en_cnt;
      exp_q[id].push_back(e);
   endtask

   task automatic mon(input int id, input logic v, input logic [63:0] s);
      exp_t e;
      if (!rst) begin
         if (last_ce) begin
            if (v) begin
               checks++;
               if (exp_q[id].size() == 0) begin
                  errors++;
                  $display("FAIL spurious_valid dut%0d: out_valid=1 sum=%0h at edge %0d, required no output",
                           id, s, en_cnt);
               end else begin
                  e = exp_q[id].pop_front();
                  if (s !== e.sum || en_cnt != e.stamp + lat[id]) begin
                     errors++;
                     $display("FAIL result dut%0d: sum=%0h at edge %0d, required sum=%0h at edge %0d",
                              id, s, en_cnt, e.sum, e.stamp + lat[id]);
                  end
               end
            end
         end else begin
            checks++;
            if (v !== prev_v[id] || s !== prev_s[id]) begin
               errors++;
               $display("FAIL stall_hold dut%0d: valid=%0b sum=%0h, required held valid=%0b sum=%0h",
                        id, v, s, prev_v[id], prev_s[id]);
            end
         end
      end
      prev_v[id] = v;
      prev_s[id] = s;
   endtask

   always @(negedge clk) begin
      mon(0, v0, 64'(s0));
      mon(1, v1, 64'(s1));
      mon(2, v2, 64'(s2));
      mon(3, v3, 64'(s3));
      mon(4, v4, 64'(s4));
      mon(5, v5, 64'(s5));
   end

   // One cycle of stimulus; e0/e1 are the hand-computed sums for the
   // unsigned and signed 5x16 trees, the small trees use ref_sum.
   task automatic step(input logic v, input logic c, input logic [79:0] d,
                       input logic [18:0] e0, input logic [18:0] e1);
      logic [95:0] r;
      @(posedge clk);
      #1;
      r        = {$urandom(), $urandom(), $urandom()};
      in_valid = v;
      ce       = c;
      d0       = d;
      d2       = r[71:0];
      d3       = r[75:74];
      d4       = r[95:72];
      d5       = r[87:80];
      if (v && c) begin
         push(0, 64'(e0));
         push(1, 64'(e1));
         push(2, ref_sum(128'(d2), 9, 8, 12));
         push(3, ref_sum(128'(d3), 2, 1, 2));
         push(4, ref_sum(128'(d4), 3, 8, 10));
         push(5, ref_sum(128'(d5), 8, 1, 4));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, {5{16'h1111}}, 19'h0, 19'h0);
   endtask

   initial begin
      rst      = 1'b1;
      ce       = 1'b1;
      in_valid = 1'b0;
      d0 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid0", 64'(v0), 64'd0);
      chk("reset_sum0",   64'(s0), 64'd0);
      chk("reset_valid1", 64'(v1), 64'd0);
      chk("reset_sum3",   64'(s3), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single vector 1..5
      step(1'b1, 1'b1, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 19'h0000F, 19'h0000F);
      idle(6);

      // Extremes: all-ones and most-negative operands
      step(1'b1, 1'b1, {5{16'hFFFF}}, 19'h4FFFB, 19'h7FFFB);
      step(1'b1, 1'b1, {5{16'h8000}}, 19'h28000, 19'h58000);
      idle(6);

      // Stream 10,20,30, bubble, 40, then a 2-cycle stall with results valid
      step(1'b1, 1'b1, {5{16'd2}}, 19'd10, 19'd10);
      step(1'b1, 1'b1, {5{16'd4}}, 19'd20, 19'd20);
      step(1'b1, 1'b1, {5{16'd6}}, 19'd30, 19'd30);
      step(1'b0, 1'b1, {5{16'd7}}, 19'd0,  19'd0);
      step(1'b1, 1'b1, {5{16'd8}}, 19'd40, 19'd40);
      idle(2);
      step(1'b1, 1'b0, {5{16'd9}}, 19'd45, 19'd45);
      step(1'b1, 1'b0, {5{16'd9}}, 19'd45, 19'd45);
      idle(8);

      // Reset two cycles after issuing a vector
      step(1'b1, 1'b1, {5{16'd3}}, 19'd15, 19'd15);
      idle(1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid0", 64'(v0), 64'd0);
      chk("async_rst_sum0",   64'(s0), 64'd0);
      chk("async_rst_sum1",   64'(s1), 64'd0);
      chk("async_rst_sum2",   64'(s2), 64'd0);
      chk("async_rst_sum4",   64'(s4), 64'd0);
      for (int i = 0; i < 6; i++) exp_q[i].delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(10);

      // Tree still works after the reset
      step(1'b1, 1'b1, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 19'h0000F, 19'h0000F);
      idle(8);

      for (int i = 0; i < 6; i++) begin
         checks++;
         if (exp_q[i].size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d: %0d results never appeared, required 0",
                     i, exp_q[i].size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipelined_adder_tree
`default_nettype wire
